// File: rtl/ble_conn_if.sv
// Link-monitor signal bundle: UART RX byte strobe and enable in,
// link event pulses and link level out.
interface ble_conn_if;
  logic       enable;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       connect;
  logic       disconnect;
  logic       time_out;
  logic       linked;

  modport master (
    output enable, rx_valid, rx_data,
    input  connect, disconnect, time_out, linked
  );

  modport slave (
    input  enable, rx_valid, rx_data,
    output connect, disconnect, time_out, linked
  );
endinterface

// File: rtl/ble_conn_monitor.sv
// BLE link monitor: matches "OK+CONN"/"OK+LOST" notifications in the RX byte
// stream and times out advertising; emits single-cycle link event pulses.
//
// state       | meaning
// OFF         | monitoring disabled, or parked after a timeout until enable re-toggles
// ADVERTISING | enabled, no link, advertisement timer running
// LINKED      | link established, waiting for "OK+LOST"
module ble_conn_monitor #(
  parameter int unsigned CLOCK_F        = 50_000_000,
  parameter int unsigned ADV_TIMEOUT_MS = 30_000
) (
  input  logic        clk,
  input  logic        rst_n,
  ble_conn_if.slave   bus
);

  localparam logic [63:0] TIMEOUT_CYCLES64 = (64'(CLOCK_F) / 64'd1000) * 64'(ADV_TIMEOUT_MS);
  localparam logic [31:0] TIMEOUT_CYCLES   = TIMEOUT_CYCLES64[31:0];
  localparam logic [31:0] TIMEOUT_LAST     = TIMEOUT_CYCLES - 32'd1;

  if (TIMEOUT_CYCLES64 > 64'h0000_0000_FFFF_FFFF) begin : g_timeout_range
    $error("ble_conn_monitor: advertisement timeout does not fit in 32 bits");
  end

  typedef enum logic [1:0] {
    OFF         = 2'd0,
    ADVERTISING = 2'd1,
    LINKED      = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  idx, idx_nxt;
  logic        sel_lost, sel_lost_nxt;
  logic        conn_hit, lost_hit;
  logic [7:0]  exp_byte;
  logic [31:0] count, count_nxt;
  logic        wait_low, wait_low_nxt;
  logic        connect_q, disconnect_q, time_out_q;
  logic        connect_nxt, disconnect_nxt, time_out_nxt;

  // Index 3 picks the suffix, so only the remaining positions need an expected byte.
  always_comb begin
    exp_byte = 8'h00;
    case (idx)
      3'd0:    exp_byte = "O";
      3'd1:    exp_byte = "K";
      3'd2:    exp_byte = "+";
      3'd4:    exp_byte = "O";
      3'd5:    exp_byte = sel_lost ? "S" : "N";
      3'd6:    exp_byte = sel_lost ? "T" : "N";
      default: exp_byte = 8'h00;
    endcase
  end

  always_comb begin
    idx_nxt      = idx;
    sel_lost_nxt = sel_lost;
    conn_hit     = 1'b0;
    lost_hit     = 1'b0;
    if (bus.rx_valid) begin
      if (idx == 3'd3 && bus.rx_data == "C") begin
        idx_nxt      = 3'd4;
        sel_lost_nxt = 1'b0;
      end else if (idx == 3'd3 && bus.rx_data == "L") begin
        idx_nxt      = 3'd4;
        sel_lost_nxt = 1'b1;
      end else if (idx != 3'd3 && bus.rx_data == exp_byte) begin
        if (idx == 3'd6) begin
          idx_nxt  = 3'd0;
          conn_hit = ~sel_lost;
          lost_hit = sel_lost;
        end else begin
          idx_nxt = idx + 3'd1;
        end
      end else begin
        // A stray 'O' may itself start a new notification.
        idx_nxt = (bus.rx_data == "O") ? 3'd1 : 3'd0;
      end
    end
    if (!bus.enable) begin
      idx_nxt      = 3'd0;
      sel_lost_nxt = 1'b0;
    end
  end

  always_comb begin
    state_nxt      = state;
    wait_low_nxt   = wait_low;
    count_nxt      = 32'd0;
    connect_nxt    = 1'b0;
    disconnect_nxt = 1'b0;
    time_out_nxt   = 1'b0;
    if (!bus.enable) begin
      state_nxt    = OFF;
      wait_low_nxt = 1'b0;
    end else begin
      case (state)
        OFF: begin
          if (!wait_low) state_nxt = ADVERTISING;
        end
        ADVERTISING: begin
          // A connect landing on the expiry cycle takes priority over the timeout.
          if (conn_hit) begin
            state_nxt   = LINKED;
            connect_nxt = 1'b1;
          end else if (count == TIMEOUT_LAST) begin
            state_nxt    = OFF;
            time_out_nxt = 1'b1;
            wait_low_nxt = 1'b1;
          end else begin
            count_nxt = count + 32'd1;
          end
        end
        LINKED: begin
          if (lost_hit) begin
            state_nxt      = ADVERTISING;
            disconnect_nxt = 1'b1;
          end
        end
        default: state_nxt = OFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= OFF;
      idx          <= 3'd0;
      sel_lost     <= 1'b0;
      count        <= 32'd0;
      wait_low     <= 1'b0;
      connect_q    <= 1'b0;
      disconnect_q <= 1'b0;
      time_out_q   <= 1'b0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      sel_lost     <= sel_lost_nxt;
      count        <= count_nxt;
      wait_low     <= wait_low_nxt;
      connect_q    <= connect_nxt;
      disconnect_q <= disconnect_nxt;
      time_out_q   <= time_out_nxt;
    end
  end

  assign bus.connect    = connect_q;
  assign bus.disconnect = disconnect_q;
  assign bus.time_out   = time_out_q;
  assign bus.linked     = (state == LINKED);

endmodule

// File: tb/tb_ble_conn_monitor.sv
// Directed bench for ble_conn_monitor with a 1000-cycle advertisement timeout.
module tb_ble_conn_monitor;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total = 0;
  int   n_conn = 0, n_disc = 0, n_to = 0, n_multi = 0;

  ble_conn_if bif ();

  ble_conn_monitor #(.CLOCK_F(1_000_000), .ADV_TIMEOUT_MS(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bif.connect === 1'b1) n_conn++;
      if (bif.disconnect === 1'b1) n_disc++;
      if (bif.time_out === 1'b1) n_to++;
      if (int'(bif.connect) + int'(bif.disconnect) + int'(bif.time_out) > 1) n_multi++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      bif.rx_valid = 1'b1;
      bif.rx_data  = s[i];
      tick(1);
    end
    bif.rx_valid = 1'b0;
    bif.rx_data  = 8'h00;
  endtask

  task automatic wait_to(input int lim, output int t);
    int k;
    k = 0;
    while (bif.time_out !== 1'b1 && k < lim) begin
      tick(1);
      k++;
    end
    t = cyc;
  endtask

  initial begin
    int c0, t, s_conn, s_disc, s_to;
    rst_n        = 1'b0;
    bif.enable   = 1'b0;
    bif.rx_valid = 1'b0;
    bif.rx_data  = 8'h00;
    tick(3);
    chk("reset_outputs", {28'd0, bif.connect, bif.disconnect, bif.time_out, bif.linked}, 32'd0);
    rst_n = 1'b1;
    tick(2);
    chk("off_idle", {28'd0, bif.connect, bif.disconnect, bif.time_out, bif.linked}, 32'd0);

    // Advertising with no traffic times out exactly once.
    s_to = n_to;
    bif.enable = 1'b1;
    c0 = cyc;
    wait_to(1100, t);
    chk("adv_timeout_latency", t - c0, 32'd1001);
    tick(1);
    chk("timeout_width", bif.time_out, 1'b0);
    tick(1200);
    chk("timeout_once", n_to - s_to, 32'd1);
    chk("no_conn_disc", n_conn + n_disc, 32'd0);

    // Connect shortly after enable.
    bif.enable = 1'b0;
    tick(2);
    bif.enable = 1'b1;
    tick(9);
    send_str("OK+CONN");
    chk("connect_pulse", bif.connect, 1'b1);
    chk("linked_rise", bif.linked, 1'b1);
    tick(1);
    chk("connect_width", bif.connect, 1'b0);
    s_to = n_to;
    tick(1100);
    chk("no_timeout_linked", n_to - s_to, 32'd0);
    chk("still_linked", bif.linked, 1'b1);

    // Link loss restarts advertising and the timer.
    send_str("OK+LOST");
    chk("disconnect_pulse", bif.disconnect, 1'b1);
    chk("linked_fall", bif.linked, 1'b0);
    c0 = cyc;
    tick(1);
    chk("disconnect_width", bif.disconnect, 1'b0);
    wait_to(1100, t);
    chk("readv_timeout_latency", t - c0, 32'd1000);

    // Mismatch recovery.
    bif.enable = 1'b0;
    tick(1);
    bif.enable = 1'b1;
    tick(2);
    s_conn = n_conn;
    send_str("OOK+CONN");
    chk("conn_after_oo", bif.connect, 1'b1);
    tick(1);
    send_str("OK+LOST");
    send_str("OK+CXOK+CONN");
    chk("conn_after_cx", bif.connect, 1'b1);
    tick(1);
    chk("conn_count_mismatch", n_conn - s_conn, 32'd2);
    send_str("OK+LOST");
    tick(1);
    s_disc = n_disc;
    send_str("OK+LOST");
    tick(2);
    chk("lost_ignored_adv", n_disc - s_disc, 32'd0);
    chk("lost_ignored_linked", bif.linked, 1'b0);

    // Final 'N' on the expiry cycle: connect wins.
    bif.enable = 1'b0;
    tick(1);
    s_to = n_to;
    bif.enable = 1'b1;
    tick(994);
    send_str("OK+CONN");
    chk("expiry_conn", bif.connect, 1'b1);
    chk("expiry_no_timeout", bif.time_out, 1'b0);
    chk("expiry_linked", bif.linked, 1'b1);
    tick(3);
    chk("expiry_timeout_count", n_to - s_to, 32'd0);

    // Enable drop discards a partial match.
    bif.enable = 1'b0;
    tick(1);
    chk("linked_after_disable", bif.linked, 1'b0);
    tick(1);
    bif.enable = 1'b1;
    tick(2);
    s_conn = n_conn;
    send_str("OK+CO");
    bif.enable = 1'b0;
    tick(2);
    bif.enable = 1'b1;
    tick(1);
    send_str("NN");
    tick(2);
    chk("partial_discarded", n_conn - s_conn, 32'd0);
    chk("partial_not_linked", bif.linked, 1'b0);

    // Reset while linked and mid-string.
    send_str("OK+CONN");
    chk("linked_before_reset", bif.linked, 1'b1);
    send_str("OK+");
    tick(3);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {28'd0, bif.connect, bif.disconnect, bif.time_out, bif.linked}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    c0 = cyc;
    s_conn = n_conn;
    send_str("CONN");
    wait_to(1100, t);
    chk("post_reset_timeout", t - c0, 32'd1001);
    chk("post_reset_no_conn", n_conn - s_conn, 32'd0);
    tick(2);
    chk("single_pulse_per_cycle", n_multi, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
